exibe_sequencia: RTL and testbench

Sequence presenter for the memory game: on `iniciar` it reads the 16x4 one-hot ROM from address 0 up to a latched limit and shows each entry on the LEDs for a fixed on-time, separated by a dark gap. It is the transmitting counterpart of the player-side checker (`circuito_exp3_desafio`), which compares `chaves` against the same ROM. It sits beside the checker and drives the LED outputs before each player round.

---
 rtl/exibe_pkg.sv | 40 ++++
 rtl/exibe_sequencia_rom_16x4.sv | 11 +
 rtl/exibe_sequencia.sv | 112 +++++++++++
 tb/tb_exibe_sequencia.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/exibe_pkg.sv
// Shared definitions for the memory-game sequence presenter and the player-side checker:
// state codes, default timings and the common 16x4 one-hot ROM contents.
package exibe_pkg;

    localparam logic [3:0] EST_INICIAL    = 4'h0;
    localparam logic [3:0] EST_PREPARACAO = 4'h1;
    localparam logic [3:0] EST_MOSTRA     = 4'h2;
    localparam logic [3:0] EST_INTERVALO  = 4'h3;
    localparam logic [3:0] EST_PROXIMO    = 4'h4;
    localparam logic [3:0] EST_FIM        = 4'hF;

    typedef enum logic [3:0] {
        INICIAL    = EST_INICIAL,
        PREPARACAO = EST_PREPARACAO,
        MOSTRA     = EST_MOSTRA,
        INTERVALO  = EST_INTERVALO,
        PROXIMO    = EST_PROXIMO,
        FIM        = EST_FIM
    } estado_t;

    localparam int T_ON_PADRAO  = 4;
    localparam int T_OFF_PADRAO = 2;

    // Same table the checker compares chaves against; edit here only.
    localparam logic [3:0] ROM_INIT [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000,
        4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100,
        4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

    function automatic int largura_timer(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/exibe_sequencia_rom_16x4.sv
// Combinational 16x4 sequence ROM, contents shared with the checker through exibe_pkg.
module rom_16x4
    import exibe_pkg::*;
(
    input  logic [3:0] endereco,
    output logic [3:0] dados
);

    assign dados = ROM_INIT[endereco];

endmodule

// File: rtl/exibe_sequencia.sv
// Sequence presenter: on iniciar, lights ROM entries 0..limite on the LEDs, each for
// T_ON cycles followed by a T_OFF-cycle dark gap, then parks in fim with pronto high.
//
// state      | meaning
// inicial    | idle after reset, waiting for iniciar
// preparacao | address/timer cleared, limite latched
// mostra     | current entry lit for T_ON cycles
// intervalo  | LEDs dark for T_OFF cycles
// proximo    | one extra dark cycle while the address advances
// fim        | sequence done, pronto high, waiting for iniciar
module exibe_sequencia
    import exibe_pkg::*;
#(
    parameter int T_ON  = T_ON_PADRAO,
    parameter int T_OFF = T_OFF_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    output logic [3:0] leds,
    output logic       pronto,
    output logic [3:0] db_endereco,
    output logic [3:0] db_estado
);

    localparam int TW = largura_timer(T_ON, T_OFF);
    localparam logic [TW-1:0] TC_ON  = TW'(T_ON - 1);
    localparam logic [TW-1:0] TC_OFF = TW'(T_OFF - 1);

    estado_t        estado;
    logic [TW-1:0]  timer;
    logic [3:0]     endereco;
    logic [3:0]     limite_reg;
    logic [3:0]     rom_end;
    logic [3:0]     rom_dados;

    // Look one address ahead in proximo so leds can be registered on the same edge
    // that the address increments.
    assign rom_end = (estado == PROXIMO) ? endereco + 4'd1 : endereco;

    rom_16x4 u_rom (
        .endereco (rom_end),
        .dados    (rom_dados)
    );

    assign db_endereco = endereco;
    assign db_estado   = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= INICIAL;
            timer      <= '0;
            endereco   <= 4'd0;
            limite_reg <= 4'd0;
            leds       <= 4'b0000;
            pronto     <= 1'b0;
        end else begin
            case (estado)
                INICIAL, FIM: begin
                    if (iniciar) begin
                        estado     <= PREPARACAO;
                        timer      <= '0;
                        endereco   <= 4'd0;
                        limite_reg <= limite;
                        pronto     <= 1'b0;
                    end
                end
                PREPARACAO: begin
                    estado <= MOSTRA;
                    timer  <= '0;
                    leds   <= rom_dados;
                end
                MOSTRA: begin
                    if (timer == TC_ON) begin
                        estado <= INTERVALO;
                        timer  <= '0;
                        leds   <= 4'b0000;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                INTERVALO: begin
                    if (timer == TC_OFF) begin
                        timer <= '0;
                        if (endereco == limite_reg) begin
                            estado <= FIM;
                            pronto <= 1'b1;
                        end else begin
                            estado <= PROXIMO;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PROXIMO: begin
                    estado   <= MOSTRA;
                    timer    <= '0;
                    endereco <= endereco + 4'd1;
                    leds     <= rom_dados;
                end
                default: begin
                    estado <= INICIAL;
                    timer  <= '0;
                    leds   <= 4'b0000;
                    pronto <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia: checkpoint table over three full runs plus
// hand-written reset and ignored-iniciar sequences.
module tb_exibe_sequencia;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] leds;
    logic       pronto;
    logic [3:0] db_endereco;
    logic [3:0] db_estado;

    int nvec = 0;
    int nbad = 0;
    int cur  = 0;

    exibe_sequencia dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .limite      (limite),
        .leds        (leds),
        .pronto      (pronto),
        .db_endereco (db_endereco),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         novo;
        logic [3:0] lim;
        int         k;
        logic [3:0] leds;
        logic       pronto;
        logic [3:0] est;
        logic [3:0] addr;
    } vec_t;

    task automatic check(input string nome, input logic [3:0] e_leds, input logic e_pronto,
                         input logic [3:0] e_est, input logic [3:0] e_addr);
        nvec++;
        if (leds !== e_leds || pronto !== e_pronto || db_estado !== e_est || db_endereco !== e_addr) begin
            nbad++;
            $display("FAIL %s: got leds=%b pronto=%b estado=%h end=%h, expected leds=%b pronto=%b estado=%h end=%h",
                     nome, leds, pronto, db_estado, db_endereco, e_leds, e_pronto, e_est, e_addr);
        end
    endtask

    // Pulse iniciar so that it is sampled on edge E0; cur counts edges after E0.
    task automatic start(input logic [3:0] lim);
        @(negedge clock);
        iniciar = 1'b1;
        limite  = lim;
        @(posedge clock);
        cur = 0;
        #1;
        iniciar = 1'b0;
    endtask

    task automatic avanca(input int k);
        int guarda;
        guarda = 0;
        while (cur < k && guarda < 2000) begin
            @(posedge clock);
            cur++;
            guarda++;
        end
        #1;
    endtask

    vec_t tab[$];

    initial begin
        // L=3 default run
        tab.push_back('{1'b1, 4'd3,  0, 4'b0000, 1'b0, 4'h1, 4'h0});
        tab.push_back('{1'b0, 4'd3,  1, 4'b0001, 1'b0, 4'h2, 4'h0});
        tab.push_back('{1'b0, 4'd3,  4, 4'b0001, 1'b0, 4'h2, 4'h0});
        tab.push_back('{1'b0, 4'd3,  5, 4'b0000, 1'b0, 4'h3, 4'h0});
        tab.push_back('{1'b0, 4'd3,  6, 4'b0000, 1'b0, 4'h3, 4'h0});
        tab.push_back('{1'b0, 4'd3,  7, 4'b0000, 1'b0, 4'h4, 4'h0});
        tab.push_back('{1'b0, 4'd3,  8, 4'b0010, 1'b0, 4'h2, 4'h1});
        tab.push_back('{1'b0, 4'd3, 11, 4'b0010, 1'b0, 4'h2, 4'h1});
        tab.push_back('{1'b0, 4'd3, 12, 4'b0000, 1'b0, 4'h3, 4'h1});
        tab.push_back('{1'b0, 4'd3, 15, 4'b0100, 1'b0, 4'h2, 4'h2});
        tab.push_back('{1'b0, 4'd3, 22, 4'b1000, 1'b0, 4'h2, 4'h3});
        tab.push_back('{1'b0, 4'd3, 25, 4'b1000, 1'b0, 4'h2, 4'h3});
        tab.push_back('{1'b0, 4'd3, 26, 4'b0000, 1'b0, 4'h3, 4'h3});
        tab.push_back('{1'b0, 4'd3, 27, 4'b0000, 1'b0, 4'h3, 4'h3});
        tab.push_back('{1'b0, 4'd3, 28, 4'b0000, 1'b1, 4'hF, 4'h3});
        tab.push_back('{1'b0, 4'd3, 31, 4'b0000, 1'b1, 4'hF, 4'h3});
        // L=0, restarted from fim
        tab.push_back('{1'b1, 4'd0,  0, 4'b0000, 1'b0, 4'h1, 4'h0});
        tab.push_back('{1'b0, 4'd0,  1, 4'b0001, 1'b0, 4'h2, 4'h0});
        tab.push_back('{1'b0, 4'd0,  4, 4'b0001, 1'b0, 4'h2, 4'h0});
        tab.push_back('{1'b0, 4'd0,  5, 4'b0000, 1'b0, 4'h3, 4'h0});
        tab.push_back('{1'b0, 4'd0,  6, 4'b0000, 1'b0, 4'h3, 4'h0});
        tab.push_back('{1'b0, 4'd0,  7, 4'b0000, 1'b1, 4'hF, 4'h0});
        // L=15, full ROM
        tab.push_back('{1'b1, 4'd15,  1, 4'b0001, 1'b0, 4'h2, 4'h0});
        tab.push_back('{1'b0, 4'd15, 29, 4'b0100, 1'b0, 4'h2, 4'h4});
        tab.push_back('{1'b0, 4'd15, 50, 4'b0001, 1'b0, 4'h2, 4'h7});
        tab.push_back('{1'b0, 4'd15, 71, 4'b0100, 1'b0, 4'h2, 4'hA});
        tab.push_back('{1'b0, 4'd15, 99, 4'b0001, 1'b0, 4'h2, 4'hE});
        tab.push_back('{1'b0, 4'd15, 105, 4'b0000, 1'b0, 4'h4, 4'hE});
        tab.push_back('{1'b0, 4'd15, 106, 4'b0100, 1'b0, 4'h2, 4'hF});
        tab.push_back('{1'b0, 4'd15, 109, 4'b0100, 1'b0, 4'h2, 4'hF});
        tab.push_back('{1'b0, 4'd15, 110, 4'b0000, 1'b0, 4'h3, 4'hF});
        tab.push_back('{1'b0, 4'd15, 112, 4'b0000, 1'b1, 4'hF, 4'hF});
        tab.push_back('{1'b0, 4'd15, 115, 4'b0000, 1'b1, 4'hF, 4'hF});

        reset   = 1'b0;
        iniciar = 1'b0;
        limite  = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_idle", 4'b0000, 1'b0, 4'h0, 4'h0);

        // reset held low on the edge that samples iniciar
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd3;
        @(posedge clock);
        #1;
        check("reset_wins", 4'b0000, 1'b0, 4'h0, 4'h0);
        @(negedge clock);
        iniciar = 1'b0;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        check("idle_after_release", 4'b0000, 1'b0, 4'h0, 4'h0);

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].novo) start(tab[i].lim);
            avanca(tab[i].k);
            check($sformatf("L%0d_E%0d", tab[i].lim, tab[i].k),
                  tab[i].leds, tab[i].pronto, tab[i].est, tab[i].addr);
        end

        // iniciar and limite changes mid-run are ignored
        start(4'd3);
        avanca(9);
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd0;
        @(posedge clock);
        cur++;
        #1;
        iniciar = 1'b0;
        check("ignore_E10", 4'b0010, 1'b0, 4'h2, 4'h1);
        avanca(15);
        check("ignore_E15", 4'b0100, 1'b0, 4'h2, 4'h2);
        avanca(22);
        check("ignore_E22", 4'b1000, 1'b0, 4'h2, 4'h3);
        avanca(27);
        check("ignore_E27", 4'b0000, 1'b0, 4'h3, 4'h3);
        avanca(28);
        check("ignore_E28", 4'b0000, 1'b1, 4'hF, 4'h3);

        // asynchronous reset mid-mostra
        start(4'd3);
        avanca(16);
        check("pre_reset_E16", 4'b0100, 1'b0, 4'h2, 4'h2);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 4'b0000, 1'b0, 4'h0, 4'h0);
        @(negedge clock);
        reset = 1'b1;
        start(4'd0);
        avanca(1);
        check("restart_E1", 4'b0001, 1'b0, 4'h2, 4'h0);
        avanca(7);
        check("restart_E7", 4'b0000, 1'b1, 4'hF, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
